// File: rtl/oclib_reset_sequencer.sv
// oclib_reset_sequencer
// Asserts a set of downstream reset domains together, holds them for
// HoldCycles, then releases them one by one (domain 0 first) with
// StaggerCycles between releases. resetN is asserted asynchronously and
// deasserted through a SyncCycles-deep synchronizer. softReset restarts
// the whole sequence.
//
// Optional build macro: OCLIB_RESET_SEQ_ACK_EN
//   Adds readyIn/error. Each stagger interval starts only after the
//   previous domain reports ready. A domain that stays silent for 256
//   cycles raises a sticky error and sequencing carries on regardless.

module oclib_reset_sequencer #(
    parameter int NumDomains    = 4,
    parameter int HoldCycles    = 16,
    parameter int StaggerCycles = 8,
    parameter int SyncCycles    = 3
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  softReset,
`ifdef OCLIB_RESET_SEQ_ACK_EN
    input  logic [NumDomains-1:0] readyIn,
    output logic                  error,
`endif
    output logic [NumDomains-1:0] resetOut,
    output logic                  busy,
    output logic                  done
);

    localparam int MaxCount = (HoldCycles > StaggerCycles) ? HoldCycles : StaggerCycles;
    localparam int CntW     = $clog2(MaxCount + 1);
    localparam int IdxW     = $clog2(NumDomains + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] StagLast = CntW'((StaggerCycles > 0) ? StaggerCycles - 1 : 0);

`ifdef OCLIB_RESET_SEQ_ACK_EN
    localparam logic [IdxW-1:0] AllIdx      = IdxW'(NumDomains);
    localparam logic [7:0]      TimeoutLast = 8'd255;
`else
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDomains - 1);
`endif

    localparam logic [1:0] StAssert  = 2'd0;
    localparam logic [1:0] StHold    = 2'd1;
    localparam logic [1:0] StRelease = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [SyncCycles-1:0] r_sync;
    logic                  w_intReset;

    logic [1:0]            r_state;
    logic [1:0]            w_state;
    logic [CntW-1:0]       r_count;
    logic [CntW-1:0]       w_count;
    logic [IdxW-1:0]       r_index;
    logic [IdxW-1:0]       w_index;
    logic [NumDomains-1:0] r_resetOut;
    logic [NumDomains-1:0] w_resetOut;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_done;

`ifdef OCLIB_RESET_SEQ_ACK_EN
    logic                  r_waitAck;
    logic                  w_waitAck;
    logic [7:0]            r_timeout;
    logic [7:0]            w_timeout;
    logic                  r_error;
    logic                  w_error;
    logic                  w_ackSel;
`endif

    // Release synchronizer: shifts ones in after resetN rises so the FSM
    // only leaves reset on a clean clock-aligned edge.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncCycles-2:0], 1'b1};
        end
    end

    assign w_intReset = ~r_sync[SyncCycles-1];

`ifdef OCLIB_RESET_SEQ_ACK_EN
    // Select the ready flag of the domain most recently released (index-1).
    always_comb begin
        w_ackSel = 1'b0;
        for (int i = 0; i < NumDomains; i++) begin
            if (r_index == IdxW'(i + 1)) begin
                w_ackSel = readyIn[i];
            end
        end
    end
`endif

    // Next-state logic; soft reset and the internal reset beat every
    // counter expiry, and every state change clears the counter.
    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_index    = r_index;
        w_resetOut = r_resetOut;
        w_done     = r_done;
`ifdef OCLIB_RESET_SEQ_ACK_EN
        w_waitAck  = r_waitAck;
        w_timeout  = r_timeout;
        w_error    = r_error;
`endif
        if (w_intReset || softReset) begin
            w_state    = StAssert;
            w_count    = '0;
            w_index    = '0;
            w_resetOut = '1;
            w_done     = 1'b0;
`ifdef OCLIB_RESET_SEQ_ACK_EN
            w_waitAck  = 1'b0;
            w_timeout  = '0;
            w_error    = 1'b0;
`endif
        end else begin
            case (r_state)
                StAssert: begin
                    w_state = StHold;
                    w_count = '0;
                end
                StHold: begin
                    if (r_count == HoldLast) begin
                        w_count = '0;
                        if (StaggerCycles == 0) begin
                            w_resetOut = '0;
                            w_index    = IdxW'(NumDomains);
                        end else begin
                            w_resetOut[0] = 1'b0;
                            w_index       = IdxW'(1);
                        end
`ifdef OCLIB_RESET_SEQ_ACK_EN
                        w_state   = StRelease;
                        w_waitAck = 1'b1;
                        w_timeout = '0;
`else
                        if ((StaggerCycles == 0) || (NumDomains == 1)) begin
                            w_state = StDone;
                        end else begin
                            w_state = StRelease;
                        end
`endif
                    end else begin
                        w_count = r_count + CntW'(1);
                    end
                end
                StRelease: begin
`ifdef OCLIB_RESET_SEQ_ACK_EN
                    if (r_waitAck) begin
                        if (w_ackSel || (r_timeout == TimeoutLast)) begin
                            if (!w_ackSel) begin
                                w_error = 1'b1;
                            end
                            w_waitAck = 1'b0;
                            w_timeout = '0;
                            w_count   = '0;
                            if (r_index == AllIdx) begin
                                w_state = StDone;
                            end
                        end else begin
                            w_timeout = r_timeout + 8'd1;
                        end
                    end else if (r_count == StagLast) begin
                        for (int i = 0; i < NumDomains; i++) begin
                            if (r_index == IdxW'(i)) begin
                                w_resetOut[i] = 1'b0;
                            end
                        end
                        w_index   = r_index + IdxW'(1);
                        w_count   = '0;
                        w_waitAck = 1'b1;
                        w_timeout = '0;
                    end else begin
                        w_count = r_count + CntW'(1);
                    end
`else
                    if (r_count == StagLast) begin
                        for (int i = 0; i < NumDomains; i++) begin
                            if (r_index == IdxW'(i)) begin
                                w_resetOut[i] = 1'b0;
                            end
                        end
                        w_index = r_index + IdxW'(1);
                        w_count = '0;
                        if (r_index == LastIdx) begin
                            w_state = StDone;
                        end
                    end else begin
                        w_count = r_count + CntW'(1);
                    end
`endif
                end
                StDone: begin
                    w_resetOut = '0;
                    w_done     = 1'b1;
                end
                default: begin
                    w_state = StAssert;
                end
            endcase
        end
    end

    // State and output registers; resetN forces every domain into reset
    // immediately without waiting for a clock.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state    <= StAssert;
            r_count    <= '0;
            r_index    <= '0;
            r_resetOut <= '1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef OCLIB_RESET_SEQ_ACK_EN
            r_waitAck  <= 1'b0;
            r_timeout  <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_count    <= w_count;
            r_index    <= w_index;
            r_resetOut <= w_resetOut;
            r_busy     <= |w_resetOut;
            r_done     <= w_done;
`ifdef OCLIB_RESET_SEQ_ACK_EN
            r_waitAck  <= w_waitAck;
            r_timeout  <= w_timeout;
            r_error    <= w_error;
`endif
        end
    end

    assign resetOut = r_resetOut;
    assign busy     = r_busy;
    assign done     = r_done;
`ifdef OCLIB_RESET_SEQ_ACK_EN
    assign error    = r_error;
`endif

endmodule
